// File: rtl/cardinal_dmem_pkg.sv
// Shared definitions for the cardinal data memory: geometry, word width,
// FSM state encoding and the parity helper.
// Optional feature macro: CARDINAL_DMEM_PARITY_EN (per-word even parity).
package cardinal_dmem_pkg;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 64;

    localparam logic ST_INIT  = 1'b0;
    localparam logic ST_READY = 1'b1;

    // Even parity bit: makes the total count of ones (data + parity) even.
    function automatic logic even_par(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/cardinal_dmem_array.sv
// Single-port synchronous RAM with a registered read port.
// The read register loads only on read cycles. A read and a write never
// share a cycle on the single port, so the register holds its value
// through writes and idle cycles. Only the read register is reset; the
// storage itself is cleared by the owner's sweep.
module cardinal_dmem_array #(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              En,
    input  logic              Wr_En,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [WIDTH-1:0]  Wr_Data,
    output logic [WIDTH-1:0]  Rd_Data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write port
    always_ff @(posedge Clock) begin
        if (En && Wr_En) begin
            mem[Addr] <= Wr_Data;
        end
    end

    // Registered read data, updated only when a read is issued
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Rd_Data <= '0;
        end else if (En && !Wr_En) begin
            Rd_Data <= mem[Addr];
        end
    end

endmodule

// File: rtl/cardinal_dmem.sv
// Cardinal data memory top: after reset the INIT sweep zeroes every entry,
// then the memory serves one load or store per cycle with one-cycle load
// latency.
// Optional feature macro: CARDINAL_DMEM_PARITY_EN adds a stored even-parity
// bit per word and a sticky Parity_Err flag checked on every load.
module cardinal_dmem
    import cardinal_dmem_pkg::*;
#(
    parameter int DEPTH = cardinal_dmem_pkg::DEPTH
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [0:7]  Mem_Addr,
    input  logic [0:63] Data_In,
    output logic [0:63] Data_Out,
    input  logic        DmemEn,
    input  logic        DmemWrEn,
    output logic        Init_Done,
    output logic        Parity_Err
);

`ifdef CARDINAL_DMEM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic              state;
    logic [ADDR_W-1:0] clr_cnt;

    logic              arr_en;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [WORD_W-1:0] arr_wdata;
    logic [WORD_W-1:0] arr_rdata;

    // RAM port mux: the clear sweep owns the port during INIT, the core afterwards
    always_comb begin
        arr_en    = 1'b0;
        arr_we    = 1'b0;
        arr_addr  = '0;
        arr_wdata = '0;
        if (state == ST_INIT) begin
            arr_en    = 1'b1;
            arr_we    = 1'b1;
            arr_addr  = clr_cnt;
            arr_wdata = '0;   // all-zero word already has even parity 0
        end else begin
            arr_en    = DmemEn;
            arr_we    = DmemWrEn;
            arr_addr  = Mem_Addr;
`ifdef CARDINAL_DMEM_PARITY_EN
            arr_wdata = {even_par(Data_In), Data_In};
`else
            arr_wdata = Data_In;
`endif
        end
    end

    // FSM and clear counter: single sweep 0..DEPTH-1, then READY without wrapping
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= ST_INIT;
            clr_cnt <= '0;
        end else if (state == ST_INIT) begin
            if (clr_cnt == LAST_IDX) begin
                state <= ST_READY;
            end else begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    assign Init_Done = (state == ST_READY);
    assign Data_Out  = arr_rdata[DATA_W-1:0];

`ifdef CARDINAL_DMEM_PARITY_EN
    logic rd_chk_p1;

    // Stage p1: remember that the read register was loaded by a core read
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rd_chk_p1 <= 1'b0;
        end else begin
            rd_chk_p1 <= (state == ST_READY) && DmemEn && !DmemWrEn;
        end
    end

    // Sticky error: odd total parity over the loaded word means corruption
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Parity_Err <= 1'b0;
        end else if (rd_chk_p1 && (^arr_rdata)) begin
            Parity_Err <= 1'b1;
        end
    end
`else
    assign Parity_Err = 1'b0;
`endif

    cardinal_dmem_array #(
        .WIDTH  (WORD_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .Clock   (Clock),
        .Reset   (Reset),
        .En      (arr_en),
        .Wr_En   (arr_we),
        .Addr    (arr_addr),
        .Wr_Data (arr_wdata),
        .Rd_Data (arr_rdata)
    );

endmodule

// File: tb/tb_cardinal_dmem.sv
// Bench for cardinal_dmem: directed scenarios plus randomized traffic,
// expected Data_Out values queued at issue time and compared by a monitor.
module tb_cardinal_dmem;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [0:7]  Mem_Addr = '0;
    logic [0:63] Data_In = '0;
    logic        DmemEn = 1'b0;
    logic        DmemWrEn = 1'b0;
    logic [0:63] Data_Out;
    logic        Init_Done;
    logic        Parity_Err;

    cardinal_dmem dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Mem_Addr   (Mem_Addr),
        .Data_In    (Data_In),
        .Data_Out   (Data_Out),
        .DmemEn     (DmemEn),
        .DmemWrEn   (DmemWrEn),
        .Init_Done  (Init_Done),
        .Parity_Err (Parity_Err)
    );

    always #5 Clock = ~Clock;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q [$];
    logic        chk_req = 1'b0;
    logic        chk_p   = 1'b0;
    logic [63:0] ref_mem [256];
    logic [63:0] last_out;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a cycle flagged at issue time presents its response after the edge
    always @(posedge Clock) chk_p <= chk_req;

    always @(negedge Clock) begin
        if (chk_p) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL data_out: got %h with no expected value queued", Data_Out);
            end else begin
                check("data_out", Data_Out, exp_q.pop_front());
            end
        end
    end

    // One bus cycle; the model only applies accesses while the memory is ready
    task automatic op(input bit en, input bit we, input logic [7:0] a,
                      input logic [63:0] d, input bit ready);
        DmemEn   = en;
        DmemWrEn = we;
        Mem_Addr = a;
        Data_In  = d;
        if (ready && en) begin
            if (we) ref_mem[a] = d;
            else    last_out = ref_mem[a];
        end
        exp_q.push_back(last_out);
        chk_req = 1'b1;
        @(posedge Clock);
        #1;
        DmemEn   = 1'b0;
        DmemWrEn = 1'b0;
        chk_req  = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        last_out = '0;
    endtask

    // Count edges until Init_Done; optionally poke the bus during the sweep
    task automatic wait_init(input bit poke, output int n);
        n = 0;
        while (!Init_Done && n < 400) begin
            if (poke && n == 3)       op(1'b1, 1'b1, 8'd5,   64'hDEADBEEF_CAFEF00D, 1'b0);
            else if (poke && n == 10) op(1'b1, 1'b1, 8'd0,   64'hDEADBEEF_CAFEF00D, 1'b0);
            else if (poke && n == 20) op(1'b1, 1'b0, 8'hFF,  64'h0, 1'b0);
            else begin
                @(posedge Clock);
                #1;
            end
            n++;
        end
    endtask

    task automatic drain();
        @(posedge Clock);
        @(negedge Clock);
        #1;
        check("queue_drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [7:0]  a;
        logic [63:0] d;

        // Reset state
        model_reset();
        repeat (3) @(posedge Clock);
        #1;
        check("rst_data_out", Data_Out, 64'd0);
        check("rst_init_done", 64'(Init_Done), 64'd0);
        check("rst_parity_err", 64'(Parity_Err), 64'd0);

        // First clear sweep with the bus idle
        Reset = 1'b0;
        wait_init(1'b0, n);
        check("init_cycles_1", 64'(n), 64'd256);
        op(1'b1, 1'b0, 8'd0,   64'h0, 1'b1);
        op(1'b1, 1'b0, 8'd128, 64'h0, 1'b1);
        op(1'b1, 1'b0, 8'd255, 64'h0, 1'b1);

        // Top address write then immediate read
        op(1'b1, 1'b1, 8'hFF, 64'h01234567_89ABCDEF, 1'b1);
        op(1'b1, 1'b0, 8'hFF, 64'h0, 1'b1);

        // Alternating write/read over 0..15
        for (int i = 0; i < 16; i++) begin
            op(1'b1, 1'b1, 8'(i), 64'(i) * 64'h01010101_01010101, 1'b1);
            op(1'b1, 1'b0, 8'(i), 64'h0, 1'b1);
        end

        // Write qualifier without request is a no-op
        op(1'b0, 1'b1, 8'd3, 64'hFFFF_0000_FFFF_0000, 1'b1);
        op(1'b1, 1'b0, 8'd3, 64'h0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            a = ($urandom % 2) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            d = {$urandom, $urandom};
            op(($urandom_range(0, 3) != 0), ($urandom % 2), a, d, 1'b1);
        end
        op(1'b1, 1'b0, 8'hFF, 64'h0, 1'b1);
        drain();
`ifndef CARDINAL_DMEM_PARITY_EN
        check("parity_tied_low", 64'(Parity_Err), 64'd0);
`endif

        // Asynchronous reset with non-zero Data_Out, then abort a sweep at count 100
        Reset = 1'b1;
        #1;
        check("async_rst_data_out", Data_Out, 64'd0);
        check("async_rst_init_done", 64'(Init_Done), 64'd0);
        model_reset();
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        repeat (100) begin
            @(posedge Clock);
            #1;
        end
        check("mid_init_not_done", 64'(Init_Done), 64'd0);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        wait_init(1'b1, n);
        check("init_cycles_2", 64'(n), 64'd256);
        op(1'b1, 1'b0, 8'd50, 64'h0, 1'b1);
        op(1'b1, 1'b0, 8'd5,  64'h0, 1'b1);
        op(1'b1, 1'b0, 8'd0,  64'h0, 1'b1);
        op(1'b1, 1'b0, 8'hFF, 64'h0, 1'b1);
        for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 8'(i), 64'h0, 1'b1);
        drain();

`ifdef CARDINAL_DMEM_PARITY_EN
        // Corrupt one stored bit and confirm the sticky error
        op(1'b1, 1'b1, 8'd7, 64'hA5A5_5A5A_0F0F_F0F0, 1'b1);
        drain();
        check("parity_clean", 64'(Parity_Err), 64'd0);
        dut.u_array.mem[7] = dut.u_array.mem[7] ^ 65'h1;
        ref_mem[7] = ref_mem[7] ^ 64'h1;
        op(1'b1, 1'b0, 8'd7, 64'h0, 1'b1);
        @(posedge Clock);
        #1;
        check("parity_err_set", 64'(Parity_Err), 64'd1);
        op(1'b1, 1'b0, 8'd0, 64'h0, 1'b1);
        op(1'b1, 1'b0, 8'd1, 64'h0, 1'b1);
        drain();
        check("parity_err_sticky", 64'(Parity_Err), 64'd1);
        Reset = 1'b1;
        #1;
        check("parity_err_reset", 64'(Parity_Err), 64'd0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
